// File: rtl/width_pack_wr.sv
// rtl/width_pack_wr.sv - packs RATIO narrow beats into one wide FIFO write word
// Holds one packed word against FIFO full; flush emits a zero-padded partial word.
module width_pack_wr #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4,
    parameter int CNT_W    = 16
) (
    input  logic                      clk_wr,
    input  logic                      rst,
    input  logic                      din_valid,
    input  logic [IN_WIDTH-1:0]       din,
    output logic                      din_ready,
    input  logic                      flush,
    input  logic                      full,
    output logic                      wr_req,
    output logic [IN_WIDTH*RATIO-1:0] wdata,
    output logic [CNT_W-1:0]          word_cnt
);
    localparam int W  = IN_WIDTH * RATIO;
    localparam int BW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [BW-1:0] LAST = BW'(RATIO - 1);

    typedef enum logic {ACC, FLUSH_WAIT} state_t;

    state_t        state;
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_nxt;
    logic [W-1:0]  pad_word;
    logic [BW-1:0] beat_cnt;
    logic [BW-1:0] beat_nxt;
    logic [BW-1:0] fill;
    logic          flush_pend;
    logic          last_beat;
    logic          accept;
    logic          xfer;
    logic          out_free;
    logic          load_word;
    logic          load_pad;
    logic          go_wait;

    assign flush_pend = (state == FLUSH_WAIT);
    assign last_beat  = (beat_cnt == LAST);
    // Only the final beat needs the output register; earlier beats just fill lanes.
    assign din_ready  = !rst && !flush_pend && !(wr_req && full && last_beat);
    assign accept     = din_valid && din_ready;
    assign xfer       = wr_req && !full;
    assign out_free   = !wr_req || xfer;
    assign load_word  = accept && last_beat;

    always_comb begin
        acc_nxt  = acc;
        beat_nxt = beat_cnt;
        if (accept) begin
            for (int k = 0; k < RATIO; k++) begin
                if (BW'(k) == beat_cnt)
                    acc_nxt[k*IN_WIDTH +: IN_WIDTH] = din;
            end
            beat_nxt = last_beat ? '0 : beat_cnt + 1'b1;
        end
    end

    // A beat accepted alongside flush is packed first, so flush sees beat_nxt.
    always_comb begin
        fill     = flush_pend ? beat_cnt : beat_nxt;
        load_pad = out_free && (flush_pend || (flush && beat_nxt != '0));
        go_wait  = !flush_pend && flush && (beat_nxt != '0) && !out_free;
        pad_word = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (BW'(k) < fill)
                pad_word[k*IN_WIDTH +: IN_WIDTH] = acc_nxt[k*IN_WIDTH +: IN_WIDTH];
        end
    end

    always_ff @(posedge clk_wr or posedge rst) begin
        if (rst) begin
            state    <= ACC;
            acc      <= '0;
            beat_cnt <= '0;
            wr_req   <= 1'b0;
            wdata    <= '0;
            word_cnt <= '0;
        end else begin
            acc      <= acc_nxt;
            beat_cnt <= load_pad ? '0 : beat_nxt;
            if (xfer)
                word_cnt <= word_cnt + 1'b1;
            if (load_word) begin
                wdata  <= acc_nxt;
                wr_req <= 1'b1;
            end else if (load_pad) begin
                wdata  <= pad_word;
                wr_req <= 1'b1;
            end else if (xfer) begin
                wr_req <= 1'b0;
            end
            case (state)
                ACC:        if (go_wait)  state <= FLUSH_WAIT;
                FLUSH_WAIT: if (out_free) state <= ACC;
                default:                  state <= ACC;
            endcase
        end
    end
endmodule

// File: tb/tb_width_pack_wr.sv
// tb/tb_width_pack_wr.sv - directed self-checking bench for width_pack_wr
module tb_width_pack_wr;
    logic        clk_wr = 1'b0;
    logic        rst = 1'b1;
    logic        din_valid = 1'b0;
    logic [7:0]  din = '0;
    logic        din_ready;
    logic        flush = 1'b0;
    logic        full = 1'b0;
    logic        wr_req;
    logic [31:0] wdata;
    logic [15:0] word_cnt;

    int checks = 0;
    int errors = 0;

    width_pack_wr #(.IN_WIDTH(8), .RATIO(4), .CNT_W(16)) dut (
        .clk_wr    (clk_wr),
        .rst       (rst),
        .din_valid (din_valid),
        .din       (din),
        .din_ready (din_ready),
        .flush     (flush),
        .full      (full),
        .wr_req    (wr_req),
        .wdata     (wdata),
        .word_cnt  (word_cnt)
    );

    always #5 clk_wr = ~clk_wr;

    task automatic tick();
        @(posedge clk_wr);
        #1;
    endtask

    task automatic beat(input logic [7:0] d);
        din_valid = 1'b1;
        din = d;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        flush = 1'b0;
        full = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din_valid = 1'b1;
        din = 8'h11;
        tick();
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL reset_din_ready got %0b exp 0", din_ready); end
        checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL reset_wr_req got %0b exp 0", wr_req); end
        checks++; if (wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 00000000", wdata); end
        checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL reset_word_cnt got %0d exp 0", word_cnt); end
        din_valid = 1'b0;
    endtask

    task automatic test_stream();
        logic [7:0] d;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            d = 8'((i + 1) * 8'h11);
            din_valid = 1'b1;
            din = d;
            #1;
            checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL stream_din_ready beat %0d got %0b exp 1", i, din_ready); end
            tick();
            if (i == 3) begin
                checks++; if (wr_req !== 1'b1) begin errors++; $display("FAIL stream_wr_req0 got %0b exp 1", wr_req); end
                checks++; if (wdata !== 32'h44332211) begin errors++; $display("FAIL stream_wdata0 got %h exp 44332211", wdata); end
                checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL stream_cnt0 got %0d exp 0", word_cnt); end
            end
            if (i == 4) begin
                checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL stream_wr_req_pulse got %0b exp 0", wr_req); end
                checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL stream_cnt1 got %0d exp 1", word_cnt); end
            end
            if (i == 7) begin
                checks++; if (wr_req !== 1'b1) begin errors++; $display("FAIL stream_wr_req1 got %0b exp 1", wr_req); end
                checks++; if (wdata !== 32'h88776655) begin errors++; $display("FAIL stream_wdata1 got %h exp 88776655", wdata); end
            end
        end
        din_valid = 1'b0;
        tick();
        checks++; if (word_cnt !== 16'd2) begin errors++; $display("FAIL stream_cnt2 got %0d exp 2", word_cnt); end
        checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL stream_idle_wr_req got %0b exp 0", wr_req); end
    endtask

    task automatic test_backpressure();
        do_reset();
        beat(8'h11); beat(8'h22); beat(8'h33);
        full = 1'b1;
        beat(8'h44);
        checks++; if (wr_req !== 1'b1) begin errors++; $display("FAIL bp_pending got %0b exp 1", wr_req); end
        beat(8'hA1); beat(8'hA2); beat(8'hA3);
        din = 8'hA4;
        #1;
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %0b exp 0", din_ready); end
        tick();
        checks++; if (wdata !== 32'h44332211) begin errors++; $display("FAIL bp_wdata_hold got %h exp 44332211", wdata); end
        checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL bp_cnt_hold got %0d exp 0", word_cnt); end
        full = 1'b0;
        #1;
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_rise got %0b exp 1", din_ready); end
        tick();
        checks++; if (wdata !== 32'hA4A3A2A1) begin errors++; $display("FAIL bp_wdata_new got %h exp a4a3a2a1", wdata); end
        checks++; if (wr_req !== 1'b1) begin errors++; $display("FAIL bp_wr_req_new got %0b exp 1", wr_req); end
        checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL bp_cnt1 got %0d exp 1", word_cnt); end
        din_valid = 1'b0;
        tick();
        checks++; if (word_cnt !== 16'd2) begin errors++; $display("FAIL bp_cnt2 got %0d exp 2", word_cnt); end
    endtask

    task automatic test_flush_partial();
        do_reset();
        beat(8'h01); beat(8'h02);
        din_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (wr_req !== 1'b1) begin errors++; $display("FAIL fp_wr_req got %0b exp 1", wr_req); end
        checks++; if (wdata !== 32'h00000201) begin errors++; $display("FAIL fp_wdata got %h exp 00000201", wdata); end
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL fp_empty_noop got %0b exp 0", wr_req); end
        checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL fp_cnt got %0d exp 1", word_cnt); end
        beat(8'h03); beat(8'h04); beat(8'h05); beat(8'h06);
        din_valid = 1'b0;
        checks++; if (wdata !== 32'h06050403) begin errors++; $display("FAIL fp_lane0_restart got %h exp 06050403", wdata); end
    endtask

    task automatic test_flush_blocked();
        do_reset();
        beat(8'h11); beat(8'h22); beat(8'h33); beat(8'h44);
        full = 1'b1;
        beat(8'h7E);
        din_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        din_valid = 1'b1;
        din = 8'h99;
        #1;
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL fb_ready_wait got %0b exp 0", din_ready); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (wdata !== 32'h44332211) begin errors++; $display("FAIL fb_wdata_hold got %h exp 44332211", wdata); end
        full = 1'b0;
        tick();
        din_valid = 1'b0;
        checks++; if (wdata !== 32'h0000007E) begin errors++; $display("FAIL fb_wdata_pad got %h exp 0000007e", wdata); end
        checks++; if (wr_req !== 1'b1) begin errors++; $display("FAIL fb_wr_req got %0b exp 1", wr_req); end
        checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL fb_cnt1 got %0d exp 1", word_cnt); end
        tick();
        checks++; if (word_cnt !== 16'd2) begin errors++; $display("FAIL fb_cnt2 got %0d exp 2", word_cnt); end
        checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL fb_idle got %0b exp 0", wr_req); end
    endtask

    task automatic test_flush_final();
        do_reset();
        beat(8'h11); beat(8'h22); beat(8'h33);
        flush = 1'b1;
        beat(8'h44);
        flush = 1'b0;
        din_valid = 1'b0;
        checks++; if (wdata !== 32'h44332211) begin errors++; $display("FAIL ff_wdata got %h exp 44332211", wdata); end
        tick();
        tick();
        checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL ff_no_extra got %0b exp 0", wr_req); end
        checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL ff_cnt got %0d exp 1", word_cnt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        beat(8'h11); beat(8'h22); beat(8'h33); beat(8'h44);
        beat(8'h55); beat(8'h66); beat(8'h77); beat(8'h88);
        full = 1'b1;
        beat(8'h01); beat(8'h02);
        din_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL ar_wr_req got %0b exp 0", wr_req); end
        checks++; if (wdata !== 32'h0) begin errors++; $display("FAIL ar_wdata got %h exp 00000000", wdata); end
        checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL ar_cnt got %0d exp 0", word_cnt); end
        #2;
        rst = 1'b0;
        full = 1'b0;
        tick();
        checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL ar_no_req got %0b exp 0", wr_req); end
        beat(8'hAA); beat(8'hBB); beat(8'hCC); beat(8'hDD);
        din_valid = 1'b0;
        checks++; if (wdata !== 32'hDDCCBBAA) begin errors++; $display("FAIL ar_repack got %h exp ddccbbaa", wdata); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_partial();
        test_flush_blocked();
        test_flush_final();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
